// File: rtl/screen_to_coord.sv
// Raster scan tracker: follows the beam position and maps each active screen
// pixel back to its 8-bit logical cell coordinate using incremental counters.
module screen_to_coord #(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int SCALE    = 2,
    parameter int X_OFFSET = 64,
    parameter int Y_OFFSET = 0,
    parameter int X_CELLS  = 256,
    parameter int Y_CELLS  = 240
) (
    input  logic       ACLK,
    input  logic       ARESETN,
    input  logic       PIX_EN,
    input  logic       SYNC_CLR,
    output logic [7:0] Xout,
    output logic [7:0] Yout,
    output logic       COORD_VALID,
    output logic       LINE_START,
    output logic       FRAME_START
);

    localparam int HW  = $clog2(H_TOTAL);
    localparam int VW  = $clog2(V_TOTAL);
    localparam int SW  = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int HW1 = HW + 1;
    localparam int VW1 = VW + 1;

    localparam logic [HW:0]   X_LO     = HW1'(X_OFFSET);
    localparam logic [HW:0]   X_SPAN   = HW1'(X_CELLS * SCALE);
    localparam logic [VW:0]   Y_LO     = VW1'(Y_OFFSET);
    localparam logic [VW:0]   Y_SPAN   = VW1'(Y_CELLS * SCALE);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);

    if (X_OFFSET + X_CELLS * SCALE > H_ACTIVE || Y_OFFSET + Y_CELLS * SCALE > V_ACTIVE
        || X_CELLS > 256 || Y_CELLS > 256 || SCALE < 1) begin : g_bad_params
        $error("screen_to_coord: logical window does not fit the active area");
    end

    logic [HW-1:0] hcnt, hcnt_n;
    logic [VW-1:0] vcnt, vcnt_n;
    logic [SW-1:0] xsub, xsub_n, ysub, ysub_n;
    logic [7:0]    xcell, xcell_n, ycell, ycell_n;
    logic [7:0]    x_n, y_n;
    logic          valid_n, ls_n, fs_n;
    logic [HW:0]   x_off;
    logic [VW:0]   y_off;
    logic          in_x, in_y, h_wrap, v_wrap;

    // Offsets wrap to large values left of/above the window, so one compare
    // per axis covers both bounds.
    assign x_off  = {1'b0, hcnt} - X_LO;
    assign y_off  = {1'b0, vcnt} - Y_LO;
    assign in_x   = x_off < X_SPAN;
    assign in_y   = y_off < Y_SPAN;
    assign h_wrap = hcnt == H_LAST;
    assign v_wrap = vcnt == V_LAST;

    // Outputs describe the pixel accepted on the previous ACLK edge. The three
    // strobes are single-cycle, have no back-pressure and are only raised on
    // the cycle after an accepted pixel; Xout/Yout hold between valid strobes.
    always_comb begin
        hcnt_n  = hcnt;
        vcnt_n  = vcnt;
        xsub_n  = xsub;
        xcell_n = xcell;
        ysub_n  = ysub;
        ycell_n = ycell;
        x_n     = Xout;
        y_n     = Yout;
        valid_n = 1'b0;
        ls_n    = 1'b0;
        fs_n    = 1'b0;
        if (SYNC_CLR) begin
            hcnt_n  = '0;
            vcnt_n  = '0;
            xsub_n  = '0;
            xcell_n = '0;
            ysub_n  = '0;
            ycell_n = '0;
        end else if (PIX_EN) begin
            ls_n = hcnt == '0;
            fs_n = (hcnt == '0) && (vcnt == '0);
            if (in_x && in_y) begin
                valid_n = 1'b1;
                x_n     = xcell;
                y_n     = ycell;
            end
            if (h_wrap) begin
                hcnt_n  = '0;
                xsub_n  = '0;
                xcell_n = '0;
                if (v_wrap) begin
                    vcnt_n  = '0;
                    ysub_n  = '0;
                    ycell_n = '0;
                end else begin
                    vcnt_n = vcnt + 1'b1;
                    if (in_y) begin
                        if (ysub == SUB_LAST) begin
                            ysub_n  = '0;
                            ycell_n = ycell + 8'd1;
                        end else begin
                            ysub_n = ysub + 1'b1;
                        end
                    end
                end
            end else begin
                hcnt_n = hcnt + 1'b1;
                if (in_x) begin
                    if (xsub == SUB_LAST) begin
                        xsub_n  = '0;
                        xcell_n = xcell + 8'd1;
                    end else begin
                        xsub_n = xsub + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            hcnt        <= '0;
            vcnt        <= '0;
            xsub        <= '0;
            xcell       <= '0;
            ysub        <= '0;
            ycell       <= '0;
            Xout        <= '0;
            Yout        <= '0;
            COORD_VALID <= 1'b0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            hcnt        <= hcnt_n;
            vcnt        <= vcnt_n;
            xsub        <= xsub_n;
            xcell       <= xcell_n;
            ysub        <= ysub_n;
            ycell       <= ycell_n;
            Xout        <= x_n;
            Yout        <= y_n;
            COORD_VALID <= valid_n;
            LINE_START  <= ls_n;
            FRAME_START <= fs_n;
        end
    end

endmodule

// File: tb/tb_screen_to_coord.sv
// Bench for screen_to_coord: default-parameter instance checked through an
// expected-output queue, plus a SCALE=1 instance run over one whole frame.
module tb_screen_to_coord;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: default parameters
    logic       rst_n = 1'b1, pix_en = 1'b0, sync_clr = 1'b0;
    logic [7:0] xout, yout;
    logic       cvalid, lstart, fstart;

    screen_to_coord dut (
        .ACLK(clk), .ARESETN(rst_n), .PIX_EN(pix_en), .SYNC_CLR(sync_clr),
        .Xout(xout), .Yout(yout), .COORD_VALID(cvalid),
        .LINE_START(lstart), .FRAME_START(fstart)
    );

    // Instance 1: SCALE=1, window at origin
    logic       rst1_n = 1'b1, en1 = 1'b0, clr1 = 1'b0;
    logic [7:0] xout1, yout1;
    logic       cvalid1, lstart1, fstart1;

    screen_to_coord #(
        .H_TOTAL(300), .V_TOTAL(250), .H_ACTIVE(280), .V_ACTIVE(245), .SCALE(1),
        .X_OFFSET(0), .Y_OFFSET(0), .X_CELLS(256), .Y_CELLS(240)
    ) dut1 (
        .ACLK(clk), .ARESETN(rst1_n), .PIX_EN(en1), .SYNC_CLR(clr1),
        .Xout(xout1), .Yout(yout1), .COORD_VALID(cvalid1),
        .LINE_START(lstart1), .FRAME_START(fstart1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard for instance 0: {valid, line_start, frame_start, x, y}
    logic [18:0] exp_q[$];
    int m_h = 0, m_v = 0, last_x = 0, last_y = 0;

    task automatic model_accept();
        bit in_w;
        in_w = (m_h >= 64) && (m_h < 64 + 256 * 2) && (m_v >= 0) && (m_v < 0 + 240 * 2);
        if (in_w) begin
            last_x = (m_h - 64) / 2;
            last_y = m_v / 2;
        end
        if (in_w || m_h == 0)
            exp_q.push_back({in_w, m_h == 0, (m_h == 0 && m_v == 0), 8'(last_x), 8'(last_y)});
        m_h++;
        if (m_h == 800) begin
            m_h = 0;
            m_v = (m_v == 524) ? 0 : m_v + 1;
        end
    endtask

    // Drives one cycle; returns the coordinates the model had before the edge.
    task automatic step0(input logic en, input logic clr, output int ph, output int pv);
        ph       = m_h;
        pv       = m_v;
        pix_en   = en;
        sync_clr = clr;
        if (clr) begin
            m_h = 0;
            m_v = 0;
        end else if (en) begin
            model_accept();
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && (cvalid || lstart || fstart)) begin
            if (exp_q.size() == 0) begin
                check("unexpected strobe", int'({cvalid, lstart, fstart}), 0);
            end else begin
                check("scoreboard out", int'({cvalid, lstart, fstart, xout, yout}),
                      int'(exp_q.pop_front()));
            end
        end
    end

    task automatic run0();
        int ph, pv;
        rst_n = 1'b0;
        #1;
        check("reset xout", int'(xout), 0);
        check("reset yout", int'(yout), 0);
        check("reset strobes", int'({cvalid, lstart, fstart}), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Three lines with PIX_EN held high
        for (int i = 0; i < 2400; i++) begin
            step0(1'b1, 1'b0, ph, pv);
            if (ph == 0 && pv == 0) check("first frame_start", int'({lstart, fstart}), 3);
            if (ph == 64 && pv == 0) check("x at 64", int'({cvalid, xout, yout}), 'h10000);
            if (ph == 65 && pv == 0) check("x at 65", int'(xout), 0);
            if (ph == 66 && pv == 0) check("x at 66", int'(xout), 1);
            if (ph == 575 && pv == 0) check("x at 575", int'({cvalid, xout}), 'h1ff);
            if (ph == 576 && pv == 0) check("x hold at 576", int'({cvalid, xout}), 'h0ff);
            if (ph == 0 && pv == 1) check("line 1 start", int'({lstart, fstart}), 2);
            if (ph == 64 && pv == 1) check("y line 1", int'(yout), 0);
            if (ph == 64 && pv == 2) check("y line 2", int'(yout), 1);
        end

        // Line 3 with PIX_EN alternating
        for (int i = 0; i < 1600; i++) begin
            step0(1'((i % 2) == 0), 1'b0, ph, pv);
            if (i == 129) check("hold cycle strobes", int'({cvalid, lstart, fstart}), 0);
        end

        // Restart on SYNC_CLR at (300,4)
        while (!(m_h == 300 && m_v == 4)) step0(1'b1, 1'b0, ph, pv);
        step0(1'b1, 1'b1, ph, pv);
        check("sync drops pixel", int'({cvalid, lstart, fstart}), 0);
        check("sync holds x/y", int'({xout, yout}), {8'd117, 8'd2});
        step0(1'b1, 1'b0, ph, pv);
        check("after sync frame_start", int'({lstart, fstart}), 3);

        // Asynchronous reset in the middle of line 50
        while (!(m_h == 200 && m_v == 50)) step0(1'b1, 1'b0, ph, pv);
        check("before reset x/y", int'({cvalid, xout, yout}), {1'b1, 8'd67, 8'd25});
        pix_en = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset x/y", int'({xout, yout}), 0);
        check("async reset strobes", int'({cvalid, lstart, fstart}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_h    = 0;
        m_v    = 0;
        last_x = 0;
        last_y = 0;
        for (int i = 0; i < 810; i++) begin
            step0(1'b1, 1'b0, ph, pv);
            if (ph == 0 && pv == 0) check("post reset frame_start", int'({lstart, fstart}), 3);
        end
        pix_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("queue drained", exp_q.size(), 0);
    endtask

    task automatic run1();
        int h, v, n_valid, n_line, n_frame;
        n_valid = 0;
        n_line  = 0;
        n_frame = 0;
        #2 rst1_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst1_n = 1'b1;
        en1    = 1'b1;
        for (int i = 0; i < 300 * 250; i++) begin
            @(posedge clk);
            #1;
            h = i % 300;
            v = i / 300;
            n_valid += int'(cvalid1);
            n_line  += int'(lstart1);
            n_frame += int'(fstart1);
            if (h == 255 && v == 0) check("s1 x 255", int'({cvalid1, xout1}), 'h1ff);
            if (h == 256 && v == 0) check("s1 x 256 hold", int'({cvalid1, xout1}), 'h0ff);
            if (h == 0 && v == 239) check("s1 y 239", int'({cvalid1, yout1}), 'h1ef);
            if (h == 0 && v == 240) check("s1 y 240 hold", int'({cvalid1, lstart1, yout1}), 'h0ef | 'h100);
        end
        check("s1 valid count", n_valid, 256 * 240);
        check("s1 line count", n_line, 250);
        check("s1 frame count", n_frame, 1);
        @(posedge clk);
        #1;
        check("s1 frame wrap", int'({cvalid1, lstart1, fstart1, xout1, yout1}), 'h70000);
        en1 = 1'b0;
    endtask

    initial begin
        fork
            run0();
            run1();
        join
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
